// File: rtl/mips_pkg.sv
// Purpose: shared types and width constants for the MEM stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] dst_reg;
    logic              mem_to_reg;
    logic              reg_write;
  } mem_wb_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Purpose: data-memory request/ack handshake; holds the request until ack.
// Latency: request same cycle as acc; completes on the cycle ack is seen.
// Backpressure: mem_stall = dmem_req & ~dmem_ack; upstream freezes meanwhile.
module dmem_access_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic acc_done
);
  import mips_pkg::*;

  mem_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MEM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (acc && !dmem_ack) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack)         state_d = MEM_IDLE;
      default:                        state_d = MEM_IDLE;
    endcase
  end

  // Gated by rst_n so an abandoned access drops the request at once.
  always_comb begin
    dmem_req = 1'b0;
    case (state_q)
      MEM_IDLE: dmem_req = acc;
      MEM_WAIT: dmem_req = 1'b1;
      default:  dmem_req = 1'b0;
    endcase
    dmem_req  = dmem_req & rst_n;
    mem_stall = dmem_req & ~dmem_ack;
    acc_done  = dmem_req & dmem_ack;
  end

endmodule

// File: rtl/mem_stage_unit.sv
// Purpose: MEM stage: branch resolve, dmem access, MEM/WB register (MEM_ALIGN_CHECK_EN adds align fault).
// Latency: 1 cycle to MEM/WB; N-wait access takes N+1 cycles with N bubbles.
// Backpressure: mem_stall holds upstream while a memory access is outstanding.
module mem_stage_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EXE_MEM_Valid,
  input  logic [DATA_W-1:0] EXE_MEM_Result,
  input  logic [DATA_W-1:0] EXE_MEM_StoreData,
  input  logic [ADDR_W-1:0] EXE_MEM_BranchAddress,
  input  logic [REG_AW-1:0] EXE_MEM_DstReg,
  input  logic              EXE_MEM_Zero,
  input  logic              BranchEqualIn,
  input  logic              BranchnotEqualIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              MemtoRegIn,
  input  logic              RegWriteIn,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] BranchTarget,
  output logic              mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              MEM_WB_AlignFault,
`endif
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [DATA_W-1:0] MEM_WB_Result,
  output logic [REG_AW-1:0] MEM_WB_DstReg,
  output logic              MEM_WB_MemtoReg,
  output logic              MEM_WB_RegWrite
);
  import mips_pkg::*;

  logic    acc_raw, acc, align_fault, acc_done;
  mem_wb_t mem_wb_q, mem_wb_d;

  assign acc_raw = EXE_MEM_Valid & (MemReadIn | MemWriteIn);

`ifdef MEM_ALIGN_CHECK_EN
  logic align_fault_q, align_fault_d;
  assign align_fault = acc_raw & (EXE_MEM_Result[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign acc        = acc_raw & ~align_fault;
  assign dmem_we    = MemWriteIn;
  assign dmem_addr  = EXE_MEM_Result[ADDR_W-1:0];
  assign dmem_wdata = EXE_MEM_StoreData;

  dmem_access_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall),
    .acc_done  (acc_done)
  );

  // Both branch bits set means always taken; a stall suppresses the redirect.
  assign PCSrc = rst_n & EXE_MEM_Valid & ~mem_stall &
                 ((BranchEqualIn & EXE_MEM_Zero) | (BranchnotEqualIn & ~EXE_MEM_Zero));
  assign BranchTarget = EXE_MEM_BranchAddress;

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (mem_stall) begin
      mem_wb_d.reg_write  = 1'b0;
      mem_wb_d.mem_to_reg = 1'b0;
    end else begin
      mem_wb_d.result     = EXE_MEM_Result;
      mem_wb_d.dst_reg    = EXE_MEM_DstReg;
      mem_wb_d.mem_to_reg = MemtoRegIn;
      mem_wb_d.reg_write  = RegWriteIn & EXE_MEM_Valid & ~align_fault;
      // Write wins over read, so a read+write access captures nothing.
      if (acc_done && MemReadIn && !MemWriteIn) mem_wb_d.read_data = dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_wb_q <= '0;
    else        mem_wb_q <= mem_wb_d;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault_d = align_fault & ~mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_fault_q <= 1'b0;
    else        align_fault_q <= align_fault_d;
  end

  assign MEM_WB_AlignFault = align_fault_q;
`endif

  assign MEM_WB_ReadData = mem_wb_q.read_data;
  assign MEM_WB_Result   = mem_wb_q.result;
  assign MEM_WB_DstReg   = mem_wb_q.dst_reg;
  assign MEM_WB_MemtoReg = mem_wb_q.mem_to_reg;
  assign MEM_WB_RegWrite = mem_wb_q.reg_write;

endmodule
